// File: rtl/tdm_pkg.sv
// Shared TDM definitions: channel count, slot numbering and receiver FSM states.
// Imported by both ends of the link so slot 0..3 mean the same channel everywhere.
package tdm_pkg;

  localparam int N_CH   = 4;
  localparam int SLOT_W = 2;

  typedef logic [SLOT_W-1:0] slot_t;

  localparam slot_t FIRST_SLOT = slot_t'(0);
  localparam slot_t LAST_SLOT  = slot_t'(N_CH - 1);

  typedef enum logic {
    TDM_IDLE,
    TDM_RUN
  } tdm_state_t;

  // Slot numbering wraps naturally at N_CH because SLOT_W is exactly log2(N_CH).
  function automatic slot_t slot_inc(input slot_t s);
    return s + slot_t'(1);
  endfunction

endpackage

// File: rtl/tdm_demux4.sv
// Four-slot TDM demultiplexer: steers serial samples into slots 0..3 and publishes
// each completed frame on a registered word with a one-cycle strobe.
module tdm_demux4
  import tdm_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [WIDTH-1:0]      din,
  input  logic                  din_valid,
  input  logic                  frame_start,
  output logic [N_CH*WIDTH-1:0] y,
  output logic                  frame_valid,
  output logic [SLOT_W-1:0]     slot,
  output logic                  locked,
  output logic                  sync_err
);

  tdm_state_t                   state_q, state_d;
  slot_t                        slot_q, slot_d;
  logic [N_CH-2:0][WIDTH-1:0]   shadow_q, shadow_d;
  logic [N_CH*WIDTH-1:0]        y_q, y_d;
  logic                         frame_valid_q, frame_valid_d;
  logic                         sync_err_q, sync_err_d;

  always_comb begin
    state_d       = state_q;
    slot_d        = slot_q;
    shadow_d      = shadow_q;
    y_d           = y_q;
    frame_valid_d = 1'b0;
    sync_err_d    = 1'b0;

    case (state_q)
      TDM_IDLE: begin
        // Unaligned samples before the first frame marker are dropped silently.
        if (din_valid && frame_start) begin
          shadow_d[0] = din;
          slot_d      = slot_inc(FIRST_SLOT);
          state_d     = TDM_RUN;
        end
      end

      TDM_RUN: begin
        if (din_valid) begin
          if (frame_start) begin
            // A marker always restarts the frame; stale slots 1..2 get overwritten
            // before they can be published, so they need no clearing.
            shadow_d[0] = din;
            slot_d      = slot_inc(FIRST_SLOT);
            sync_err_d  = (slot_q != FIRST_SLOT);
          end else if (slot_q == LAST_SLOT) begin
            y_d           = {din, shadow_q};
            frame_valid_d = 1'b1;
            slot_d        = FIRST_SLOT;
          end else begin
            case (slot_q)
              2'd0:    shadow_d[0] = din;
              2'd1:    shadow_d[1] = din;
              default: shadow_d[2] = din;
            endcase
            slot_d = slot_inc(slot_q);
          end
        end
      end

      default: state_d = TDM_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= TDM_IDLE;
      slot_q        <= FIRST_SLOT;
      shadow_q      <= '0;
      y_q           <= '0;
      frame_valid_q <= 1'b0;
      sync_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      slot_q        <= slot_d;
      shadow_q      <= shadow_d;
      y_q           <= y_d;
      frame_valid_q <= frame_valid_d;
      sync_err_q    <= sync_err_d;
    end
  end

  assign y           = y_q;
  assign frame_valid = frame_valid_q;
  assign slot        = slot_q;
  assign locked      = (state_q == TDM_RUN);
  assign sync_err    = sync_err_q;

endmodule

// File: tb/tb_tdm_demux4.sv
// Scoreboard bench for tdm_demux4 at WIDTH=1 and WIDTH=8.
module tb_tdm_demux4;

  logic        clk = 1'b0;
  logic        rst_n;
  always #5 clk = ~clk;

  logic        din1, vld1, fs1;
  logic [3:0]  y1;
  logic        fv1, lk1, se1;
  logic [1:0]  slot1;

  logic [7:0]  din8;
  logic        vld8, fs8;
  logic [31:0] y8;
  logic        fv8, lk8, se8;
  logic [1:0]  slot8;

  tdm_demux4 #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .din(din1), .din_valid(vld1), .frame_start(fs1),
    .y(y1), .frame_valid(fv1), .slot(slot1), .locked(lk1), .sync_err(se1)
  );

  tdm_demux4 #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .din(din8), .din_valid(vld8), .frame_start(fs8),
    .y(y8), .frame_valid(fv8), .slot(slot8), .locked(lk8), .sync_err(se8)
  );

  int checks = 0;
  int failures = 0;
  logic [3:0]  q1[$];
  logic [31:0] q8[$];
  logic [3:0]  exp1;
  logic [31:0] exp8;
  int fv_cnt1 = 0, se_cnt1 = 0, fv_cnt8 = 0;
  int cyc = 0;
  int fv8_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitors: every frame strobe must match the oldest expected frame.
  always @(negedge clk) begin
    if (se1 === 1'b1) se_cnt1++;
    if (fv1 === 1'b1) begin
      fv_cnt1++;
      checks++;
      if (q1.size() == 0) begin
        failures++;
        $display("FAIL sb1_unexpected_frame y=%b expected no frame", y1);
      end else begin
        exp1 = q1.pop_front();
        if (y1 !== exp1) begin
          failures++;
          $display("FAIL sb1_frame got=%b exp=%b", y1, exp1);
        end
      end
      checks++;
      if (se1 !== 1'b0) begin
        failures++;
        $display("FAIL sb1_pulse_overlap sync_err=%b exp=0", se1);
      end
    end
  end

  always @(negedge clk) begin
    if (fv8 === 1'b1) begin
      fv_cnt8++;
      fv8_cyc.push_back(cyc);
      checks++;
      if (q8.size() == 0) begin
        failures++;
        $display("FAIL sb8_unexpected_frame y=%h expected no frame", y8);
      end else begin
        exp8 = q8.pop_front();
        if (y8 !== exp8) begin
          failures++;
          $display("FAIL sb8_frame got=%h exp=%h", y8, exp8);
        end
      end
    end
  end

  task automatic put1(input logic d, input logic f);
    @(negedge clk);
    din1 = d; fs1 = f; vld1 = 1'b1;
  endtask

  task automatic idle1();
    @(negedge clk);
    vld1 = 1'b0; fs1 = 1'b0;
  endtask

  task automatic put8(input logic [7:0] d, input logic f);
    @(negedge clk);
    din8 = d; fs8 = f; vld8 = 1'b1;
  endtask

  task automatic idle8();
    @(negedge clk);
    vld8 = 1'b0; fs8 = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    vld1 = 1'b0; fs1 = 1'b0; vld8 = 1'b0; fs8 = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    din1 = 1'b0; vld1 = 1'b0; fs1 = 1'b0;
    din8 = 8'h00; vld8 = 1'b0; fs8 = 1'b0;
    #2;
    checks++;
    if ({y1, fv1, slot1, lk1, se1} !== 9'b0) begin
      failures++;
      $display("FAIL reset_w1 got y=%b fv=%b slot=%0d locked=%b serr=%b exp all 0", y1, fv1, slot1, lk1, se1);
    end
    checks++;
    if ({y8, fv8, slot8, lk8, se8} !== 37'b0) begin
      failures++;
      $display("FAIL reset_w8 got y=%h fv=%b slot=%0d locked=%b serr=%b exp all 0", y8, fv8, slot8, lk8, se8);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int n;
    n = fv_cnt1;
    q1.push_back(4'b0110);
    put1(1'b0, 1'b1); put1(1'b1, 1'b0); put1(1'b1, 1'b0); put1(1'b0, 1'b0);
    idle1();
    checks++;
    if (fv1 !== 1'b1 || y1 !== 4'b0110) begin
      failures++;
      $display("FAIL basic_frame got fv=%b y=%b exp fv=1 y=0110", fv1, y1);
    end
    checks++;
    if (slot1 !== 2'd0 || lk1 !== 1'b1) begin
      failures++;
      $display("FAIL basic_state got slot=%0d locked=%b exp slot=0 locked=1", slot1, lk1);
    end
    idle1();
    checks++;
    if (fv1 !== 1'b0 || fv_cnt1 - n != 1) begin
      failures++;
      $display("FAIL basic_single_strobe got fv=%b frames=%0d exp fv=0 frames=1", fv1, fv_cnt1 - n);
    end
  endtask

  task automatic test_before_lock();
    int n, s;
    do_reset();
    n = fv_cnt1;
    s = se_cnt1;
    for (int i = 0; i < 5; i++) put1(1'(i % 2), 1'b0);
    idle1();
    checks++;
    if (lk1 !== 1'b0 || slot1 !== 2'd0) begin
      failures++;
      $display("FAIL prelock_discard got locked=%b slot=%0d exp locked=0 slot=0", lk1, slot1);
    end
    q1.push_back(4'b1001);
    put1(1'b1, 1'b1);
    put1(1'b0, 1'b0);
    checks++;
    if (lk1 !== 1'b1 || slot1 !== 2'd1) begin
      failures++;
      $display("FAIL prelock_lock got locked=%b slot=%0d exp locked=1 slot=1", lk1, slot1);
    end
    put1(1'b0, 1'b0);
    put1(1'b1, 1'b0);
    idle1(); idle1();
    checks++;
    if (fv_cnt1 - n != 1 || se_cnt1 != s || y1 !== 4'b1001) begin
      failures++;
      $display("FAIL prelock_frame got frames=%0d serr=%0d y=%b exp frames=1 serr=0 y=1001",
               fv_cnt1 - n, se_cnt1 - s, y1);
    end
  endtask

  task automatic test_gaps();
    logic [3:0] pat;
    int n;
    pat = 4'b1011;
    n = fv_cnt1;
    q1.push_back(pat);
    for (int i = 0; i < 4; i++) begin
      put1(pat[i], i == 0);
      if (i < 3) begin
        repeat (3) idle1();
        checks++;
        if (slot1 !== 2'(i + 1) || fv1 !== 1'b0) begin
          failures++;
          $display("FAIL gaps_hold_%0d got slot=%0d fv=%b exp slot=%0d fv=0", i, slot1, fv1, i + 1);
        end
      end
    end
    idle1();
    checks++;
    if (fv1 !== 1'b1) begin
      failures++;
      $display("FAIL gaps_latency got fv=%b exp 1", fv1);
    end
    repeat (3) idle1();
    checks++;
    if (fv_cnt1 - n != 1) begin
      failures++;
      $display("FAIL gaps_count got frames=%0d exp 1", fv_cnt1 - n);
    end
  endtask

  task automatic test_resync();
    int n, s;
    n = fv_cnt1;
    s = se_cnt1;
    q1.push_back(4'b1000);
    put1(1'b1, 1'b1);
    put1(1'b1, 1'b0);
    put1(1'b0, 1'b1);
    @(negedge clk);
    checks++;
    if (se1 !== 1'b1 || fv1 !== 1'b0 || y1 !== 4'b1011 || slot1 !== 2'd1) begin
      failures++;
      $display("FAIL resync_pulse got serr=%b fv=%b y=%b slot=%0d exp serr=1 fv=0 y=1011 slot=1",
               se1, fv1, y1, slot1);
    end
    din1 = 1'b0; fs1 = 1'b0; vld1 = 1'b1;
    put1(1'b0, 1'b0);
    checks++;
    if (se1 !== 1'b0 || slot1 !== 2'd2) begin
      failures++;
      $display("FAIL resync_one_cycle got serr=%b slot=%0d exp serr=0 slot=2", se1, slot1);
    end
    put1(1'b1, 1'b0);
    idle1(); idle1();
    checks++;
    if (fv_cnt1 - n != 1 || se_cnt1 - s != 1 || y1 !== 4'b1000) begin
      failures++;
      $display("FAIL resync_frame got frames=%0d serr=%0d y=%b exp frames=1 serr=1 y=1000",
               fv_cnt1 - n, se_cnt1 - s, y1);
    end
  endtask

  task automatic test_async_reset();
    q1.push_back(4'b0110);
    put1(1'b0, 1'b1); put1(1'b1, 1'b0); put1(1'b1, 1'b0); put1(1'b0, 1'b0);
    idle1(); idle1();
    put1(1'b0, 1'b1); put1(1'b1, 1'b0); put1(1'b0, 1'b0);
    idle1();
    checks++;
    if (y1 !== 4'b0110 || slot1 !== 2'd3 || lk1 !== 1'b1) begin
      failures++;
      $display("FAIL areset_pre got y=%b slot=%0d locked=%b exp y=0110 slot=3 locked=1", y1, slot1, lk1);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (y1 !== 4'b0000 || lk1 !== 1'b0 || slot1 !== 2'd0) begin
      failures++;
      $display("FAIL areset_immediate got y=%b locked=%b slot=%0d exp y=0000 locked=0 slot=0", y1, lk1, slot1);
    end
    @(negedge clk);
    rst_n = 1'b1;
    q1.push_back(4'b1010);
    put1(1'b0, 1'b1); put1(1'b1, 1'b0); put1(1'b0, 1'b0); put1(1'b1, 1'b0);
    idle1();
    checks++;
    if (fv1 !== 1'b1 || y1 !== 4'b1010) begin
      failures++;
      $display("FAIL areset_after got fv=%b y=%b exp fv=1 y=1010", fv1, y1);
    end
    idle1();
  endtask

  task automatic test_back_to_back_w8();
    int n, c0, c1;
    n = fv_cnt8;
    fv8_cyc.delete();
    q8.push_back(32'hD3C2B1A0);
    q8.push_back(32'h44332211);
    put8(8'hA0, 1'b1); put8(8'hB1, 1'b0); put8(8'hC2, 1'b0); put8(8'hD3, 1'b0);
    put8(8'h11, 1'b0); put8(8'h22, 1'b0); put8(8'h33, 1'b0); put8(8'h44, 1'b0);
    idle8(); idle8();
    checks++;
    if (fv_cnt8 - n != 2 || fv8_cyc.size() != 2) begin
      failures++;
      $display("FAIL w8_frame_count got %0d exp 2", fv_cnt8 - n);
    end else begin
      c0 = fv8_cyc[0];
      c1 = fv8_cyc[1];
      checks++;
      if (c1 - c0 != 4) begin
        failures++;
        $display("FAIL w8_spacing got %0d cycles exp 4", c1 - c0);
      end
    end
    checks++;
    if (y8 !== 32'h44332211 || se8 !== 1'b0) begin
      failures++;
      $display("FAIL w8_final got y=%h serr=%b exp y=44332211 serr=0", y8, se8);
    end
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_before_lock();
    test_gaps();
    test_resync();
    test_async_reset();
    test_back_to_back_w8();
    repeat (2) @(negedge clk);
    checks++;
    if (q1.size() != 0 || q8.size() != 0) begin
      failures++;
      $display("FAIL sb_leftover got q1=%0d q8=%0d exp 0 0", q1.size(), q8.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
